// File: rtl/issue_scoreboard_if.sv
// Decode/writeback/stall-control bundle between the pipeline and the issue scoreboard.
// master = pipeline side (drives decode and writeback), slave = scoreboard.
interface issue_scoreboard_if #(
    parameter int REGISTER_SIZE = 5,
    parameter int MAX_PENDING   = 8
);
    localparam int NUM_REGS = 2 ** REGISTER_SIZE;
    localparam int COUNT_W  = $clog2(MAX_PENDING) + 1;

    logic                     dec_valid;
    logic [REGISTER_SIZE-1:0] dec_rs1_addr;
    logic [REGISTER_SIZE-1:0] dec_rs2_addr;
    logic                     dec_rs1_used;
    logic                     dec_rs2_used;
    logic [REGISTER_SIZE-1:0] dec_rd_addr;
    logic                     dec_rd_write;
    logic                     dec_long_latency;
    logic                     dec_fence;
    logic                     dec_branch_taken;
    logic                     wb_enable;
    logic [REGISTER_SIZE-1:0] wb_addr;

    logic                     issue;
    logic                     f_to_d_enable_ff;
    logic                     d_to_e_enable_ff;
    logic                     bubble_e;
    logic                     flush_d;
    logic [NUM_REGS-1:0]      pending_mask;
    logic [COUNT_W-1:0]       pending_count;
    logic                     busy;

    modport master (
        output dec_valid, dec_rs1_addr, dec_rs2_addr, dec_rs1_used, dec_rs2_used,
               dec_rd_addr, dec_rd_write, dec_long_latency, dec_fence, dec_branch_taken,
               wb_enable, wb_addr,
        input  issue, f_to_d_enable_ff, d_to_e_enable_ff, bubble_e, flush_d,
               pending_mask, pending_count, busy
    );

    modport slave (
        input  dec_valid, dec_rs1_addr, dec_rs2_addr, dec_rs1_used, dec_rs2_used,
               dec_rd_addr, dec_rd_write, dec_long_latency, dec_fence, dec_branch_taken,
               wb_enable, wb_addr,
        output issue, f_to_d_enable_ff, d_to_e_enable_ff, bubble_e, flush_d,
               pending_mask, pending_count, busy
    );
endinterface

// File: rtl/issue_scoreboard.sv
// In-order issue scoreboard: tracks long-latency destination registers, stalls decode on
// RAW/WAW hazards, drains outstanding writes for FENCE and squashes decode after taken branches.
module issue_scoreboard #(
    parameter int REGISTER_SIZE = 5,
    parameter int MAX_PENDING   = 8
) (
    input logic           clk,
    input logic           rst,
    issue_scoreboard_if.slave sb
);
    localparam int NUM_REGS = 2 ** REGISTER_SIZE;
    localparam int COUNT_W  = $clog2(MAX_PENDING) + 1;

    typedef enum logic [1:0] {RUN, DRAIN, FLUSH} state_t;

    state_t              state_q, state_d;
    logic [NUM_REGS-1:0] pending_q;
    logic [COUNT_W-1:0]  count_q;

    logic hazard;
    logic fence_wait;
    logic issue_c;
    logic flush_c;
    logic set_pend;
    logic clr_pend;

    // Hazards look only at registered pending bits; a same-cycle writeback is seen next cycle.
    assign hazard = (sb.dec_rs1_used && (sb.dec_rs1_addr != '0) && pending_q[sb.dec_rs1_addr])
                 || (sb.dec_rs2_used && (sb.dec_rs2_addr != '0) && pending_q[sb.dec_rs2_addr])
                 || (sb.dec_rd_write && (sb.dec_rd_addr  != '0) && pending_q[sb.dec_rd_addr])
                 || (sb.dec_rd_write && sb.dec_long_latency
                     && (count_q == COUNT_W'(MAX_PENDING)));

    assign fence_wait = sb.dec_fence && (count_q != '0);

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        issue_c = 1'b0;
        flush_c = 1'b0;
        case (state_q)
            RUN: begin
                issue_c = sb.dec_valid && !hazard && !fence_wait;
                if (sb.dec_valid && fence_wait) begin
                    state_d = DRAIN;
                end else if (issue_c && sb.dec_branch_taken) begin
                    state_d = FLUSH;
                end
            end
            DRAIN: begin
                if (count_q == '0) begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                flush_c = 1'b1;
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
        if (rst) begin
            issue_c = 1'b0;
            flush_c = 1'b0;
        end
    end

    // A set and a clear never hit the same register: a pending rd blocks its own issue.
    assign set_pend = issue_c && sb.dec_rd_write && sb.dec_long_latency && (sb.dec_rd_addr != '0);
    assign clr_pend = sb.wb_enable && (sb.wb_addr != '0) && pending_q[sb.wb_addr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the pending vector is plain flops and is reset, so a reset mid-DRAIN needs no writebacks.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            state_q <= state_d;
            if (clr_pend) begin
                pending_q[sb.wb_addr] <= 1'b0;
            end
            if (set_pend) begin
                pending_q[sb.dec_rd_addr] <= 1'b1;
            end
            if (set_pend && !clr_pend) begin
                count_q <= count_q + COUNT_W'(1);
            end else if (clr_pend && !set_pend) begin
                count_q <= count_q - COUNT_W'(1);
            end
        end
    end

    assign sb.issue            = issue_c;
    assign sb.bubble_e         = !issue_c;
    assign sb.d_to_e_enable_ff = !rst;
    assign sb.f_to_d_enable_ff = !rst && (!(sb.dec_valid && !issue_c) || (state_q == FLUSH));
    assign sb.flush_d          = flush_c;
    assign sb.pending_mask     = rst ? '0 : pending_q;
    assign sb.pending_count    = rst ? '0 : count_q;
    assign sb.busy             = !rst && ((count_q != '0) || (state_q != RUN));

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: a set-of-pending-registers model checked every cycle,
// plus literal expectations on the load-use, fence, branch, capacity, x0 and reset scenarios.
module tb_issue_scoreboard;
    localparam int RS = 5;
    localparam int MP = 8;
    localparam int NR = 1 << RS;
    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_FLUSH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    issue_scoreboard_if #(.REGISTER_SIZE(RS), .MAX_PENDING(MP)) sb ();
    issue_scoreboard #(.REGISTER_SIZE(RS), .MAX_PENDING(MP)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: a set of pending registers and a mode ----------------
    bit m_pend [NR];
    int m_mode = M_RUN;

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < NR; i++) c += int'(m_pend[i]);
        return c;
    endfunction

    function automatic bit m_waits_on(input logic [RS-1:0] r);
        return (r != '0) && m_pend[r];
    endfunction

    function automatic bit m_issue();
        bit haz;
        if (rst) return 1'b0;
        haz = (sb.dec_rs1_used && m_waits_on(sb.dec_rs1_addr))
           || (sb.dec_rs2_used && m_waits_on(sb.dec_rs2_addr))
           || (sb.dec_rd_write && m_waits_on(sb.dec_rd_addr))
           || (sb.dec_rd_write && sb.dec_long_latency && m_count() == MP);
        return sb.dec_valid && (m_mode == M_RUN) && !haz && !(sb.dec_fence && m_count() != 0);
    endfunction

    always @(posedge clk) begin : model_update
        int c;
        bit ei;
        c  = m_count();
        ei = m_issue();
        if (rst) begin
            for (int i = 0; i < NR; i++) m_pend[i] = 1'b0;
            m_mode = M_RUN;
        end else begin
            if (sb.wb_enable && sb.wb_addr != '0) m_pend[sb.wb_addr] = 1'b0;
            if (ei && sb.dec_rd_write && sb.dec_long_latency && sb.dec_rd_addr != '0)
                m_pend[sb.dec_rd_addr] = 1'b1;
            case (m_mode)
                M_RUN: begin
                    if (sb.dec_valid && sb.dec_fence && c != 0) m_mode = M_DRAIN;
                    else if (ei && sb.dec_branch_taken)         m_mode = M_FLUSH;
                end
                M_DRAIN: if (c == 0) m_mode = M_RUN;
                default: m_mode = M_RUN;
            endcase
        end
    end

    always @(negedge clk) begin : compare
        bit ei;
        logic [NR-1:0] em;
        ei = m_issue();
        for (int i = 0; i < NR; i++) em[i] = !rst && m_pend[i];
        check("issue",         sb.issue, ei);
        check("bubble_e",      sb.bubble_e, !ei);
        check("d_to_e_enable", sb.d_to_e_enable_ff, !rst);
        check("f_to_d_enable", sb.f_to_d_enable_ff,
              !rst && (!(sb.dec_valid && !ei) || m_mode == M_FLUSH));
        check("flush_d",       sb.flush_d, !rst && m_mode == M_FLUSH);
        check("pending_mask",  sb.pending_mask, em);
        check("pending_count", sb.pending_count, rst ? 0 : m_count());
        check("busy",          sb.busy, !rst && (m_count() != 0 || m_mode != M_RUN));
    end

    // ---------------- stimulus helpers ----------------
    task automatic dec(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                       input int rd, input bit w, input bit ll, input bit f, input bit br);
        sb.dec_valid        = v;
        sb.dec_rs1_addr     = RS'(rs1);
        sb.dec_rs1_used     = u1;
        sb.dec_rs2_addr     = RS'(rs2);
        sb.dec_rs2_used     = u2;
        sb.dec_rd_addr      = RS'(rd);
        sb.dec_rd_write     = w;
        sb.dec_long_latency = ll;
        sb.dec_fence        = f;
        sb.dec_branch_taken = br;
    endtask

    task automatic wb(input bit en, input int a);
        sb.wb_enable = en;
        sb.wb_addr   = RS'(a);
    endtask

    task automatic idle();
        dec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        wb(0, 0);
    endtask

    task automatic load(input int rd);  dec(1, 0, 0, 0, 0, rd, 1, 1, 0, 0); endtask
    task automatic alu(input int rs1, input int rd); dec(1, rs1, 1, 0, 0, rd, 1, 0, 0, 0); endtask
    task automatic fence(); dec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); endtask
    task automatic settle(); @(negedge clk); #1; endtask
    task automatic adv();    @(posedge clk); #1; endtask

    initial begin
        // Reset: outputs gated even with a valid instruction presented.
        idle();
        sb.dec_valid = 1'b1;
        settle();
        check("rst_issue", sb.issue, 0);
        check("rst_bubble", sb.bubble_e, 1);
        check("rst_f_to_d", sb.f_to_d_enable_ff, 0);
        check("rst_d_to_e", sb.d_to_e_enable_ff, 0);
        check("rst_busy", sb.busy, 0);
        adv(); adv();
        rst = 1'b0;
        idle();
        settle();
        check("post_rst_count", sb.pending_count, 0);
        check("post_rst_f_to_d", sb.f_to_d_enable_ff, 1);
        adv();

        // Load-use on x5.
        load(5);   settle(); check("lu_load_issue", sb.issue, 1); adv();
        alu(5, 6); settle();
        check("lu_stall_issue", sb.issue, 0);
        check("lu_stall_bubble", sb.bubble_e, 1);
        check("lu_stall_f_to_d", sb.f_to_d_enable_ff, 0);
        check("lu_count", sb.pending_count, 1);
        check("lu_mask", sb.pending_mask, 32'h0000_0020);
        adv();
        settle(); check("lu_stall2_issue", sb.issue, 0); adv();
        wb(1, 5); settle(); check("lu_wb_no_bypass", sb.issue, 0); adv();
        wb(0, 0); settle();
        check("lu_resume_issue", sb.issue, 1);
        check("lu_resume_count", sb.pending_count, 0);
        adv();
        idle(); adv();

        // Fence drain with x3 and x4 outstanding.
        load(3); adv();
        load(4); settle(); check("fd_load4_issue", sb.issue, 1); adv();
        fence(); settle();
        check("fd_fence_blocked", sb.issue, 0);
        check("fd_count2", sb.pending_count, 2);
        adv();
        wb(1, 3); settle();
        check("fd_drain_busy", sb.busy, 1);
        check("fd_drain_issue", sb.issue, 0);
        adv();
        wb(1, 4); adv();
        wb(0, 0); settle();
        check("fd_zero_count", sb.pending_count, 0);
        check("fd_zero_busy", sb.busy, 1);
        check("fd_zero_issue", sb.issue, 0);
        adv();
        settle();
        check("fd_fence_issue", sb.issue, 1);
        check("fd_run_busy", sb.busy, 0);
        adv();
        idle(); adv();

        // Taken branch then flush cycle.
        dec(1, 0, 0, 0, 0, 1, 1, 0, 0, 1); settle(); check("br_issue", sb.issue, 1); adv();
        alu(0, 2); settle();
        check("br_flush", sb.flush_d, 1);
        check("br_flush_issue", sb.issue, 0);
        check("br_flush_f_to_d", sb.f_to_d_enable_ff, 1);
        adv();
        settle();
        check("br_after_flush", sb.flush_d, 0);
        check("br_after_issue", sb.issue, 1);
        adv();
        idle(); adv();

        // A stalled taken branch must not flush until it actually issues.
        load(7); adv();
        dec(1, 7, 1, 0, 0, 0, 0, 0, 0, 1); settle(); check("sbr_stall", sb.issue, 0); adv();
        wb(1, 7); settle();
        check("sbr_no_flush", sb.flush_d, 0);
        check("sbr_stall2", sb.issue, 0);
        adv();
        wb(0, 0); settle(); check("sbr_issue", sb.issue, 1); adv();
        idle(); settle(); check("sbr_flush", sb.flush_d, 1); adv();
        adv();

        // Capacity: x1..x8 outstanding, x9 waits for a free slot.
        for (int i = 1; i <= 8; i++) begin
            load(i); adv();
        end
        load(9); settle();
        check("cap_full_stall", sb.issue, 0);
        check("cap_full_count", sb.pending_count, 8);
        adv();
        wb(1, 2); settle(); check("cap_wb_no_bypass", sb.issue, 0); adv();
        wb(0, 0); settle();
        check("cap_ninth_issue", sb.issue, 1);
        check("cap_count7", sb.pending_count, 7);
        adv();
        idle(); settle();
        check("cap_count8", sb.pending_count, 8);
        check("cap_mask", sb.pending_mask, 32'h0000_03FA);
        adv();
        foreach (m_pend[i]) begin
            if (i != 0 && i != 2 && i <= 9) begin
                wb(1, i); adv();
            end
        end
        wb(0, 0); settle(); check("cap_drained", sb.pending_count, 0); adv();

        // x0 and writeback corner cases.
        load(0); settle(); check("x0_issue", sb.issue, 1); adv();
        idle(); settle(); check("x0_count", sb.pending_count, 0); adv();
        wb(1, 7); adv();
        wb(0, 0); settle();
        check("wb_idle_count", sb.pending_count, 0);
        check("wb_idle_mask", sb.pending_mask, 0);
        adv();
        load(11); adv();
        load(10); wb(1, 11); settle();
        check("setclr_issue", sb.issue, 1);
        check("setclr_count_before", sb.pending_count, 1);
        adv();
        idle(); settle();
        check("setclr_count", sb.pending_count, 1);
        check("setclr_mask", sb.pending_mask, 32'h0000_0400);
        adv();
        wb(1, 10); adv();
        wb(0, 0); adv();

        // Reset while draining with three loads outstanding.
        load(1); adv();
        load(2); adv();
        load(3); adv();
        fence(); settle(); check("rd_count3", sb.pending_count, 3); adv();
        settle(); check("rd_in_drain", sb.busy, 1);
        rst = 1'b1;
        settle(); check("rd_rst_issue", sb.issue, 0);
        adv();
        rst = 1'b0;
        idle(); settle();
        check("rd_mask", sb.pending_mask, 0);
        check("rd_count", sb.pending_count, 0);
        check("rd_busy", sb.busy, 0);
        adv();
        load(5); settle(); check("rd_run_issue", sb.issue, 1); adv();
        idle(); wb(1, 5); adv();
        wb(0, 0); adv();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/issue_scoreboard.md
ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 Parameter REGISTER_SIZE, default 5, register address width; the register file holds 2^REGISTER_SIZE entries.
REQ-002 Parameter MAX_PENDING, default 8, maximum number of outstanding long-latency writes.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 dec_valid  input  1  decode stage holds a valid instruction.
REQ-006 dec_rs1_addr / dec_rs2_addr  input  REGISTER_SIZE each  source register addresses.
REQ-007 dec_rs1_used / dec_rs2_used  input  1 each  instruction reads rs1 / rs2.
REQ-008 dec_rd_addr  input  REGISTER_SIZE  destination register address.
REQ-009 dec_rd_write  input  1  instruction writes rd.
REQ-010 dec_long_latency  input  1  result not forwardable next cycle (load, mul/div).
REQ-011 dec_fence  input  1  instruction is FENCE.
REQ-012 dec_branch_taken  input  1  instruction redirects PC (taken branch, JAL, JALR).
REQ-013 wb_enable / wb_addr  input  1 / REGISTER_SIZE  register file writeback port.
REQ-014 issue  output  1  decode instruction advances to execute this cycle.
REQ-015 f_to_d_enable_ff  output  1  fetch-to-decode register enable.
REQ-016 d_to_e_enable_ff  output  1  decode-to-execute register enable.
REQ-017 bubble_e  output  1  execute stage loads a NOP.
REQ-018 flush_d  output  1  squash the fetch-to-decode register contents.
REQ-019 pending_mask  output  2^REGISTER_SIZE  per-register pending bits (registered).
REQ-020 pending_count  output  clog2(MAX_PENDING)+1  outstanding long-latency writes (registered).
REQ-021 busy  output  1  pending_count != 0 or state != RUN.

Function
REQ-022 The FSM SHALL have states RUN, DRAIN and FLUSH.
REQ-023 hazard SHALL be: (rs1_used & rs1 != 0 & pending[rs1]) | (rs2_used & rs2 != 0 & pending[rs2]) | (rd_write & rd != 0 & pending[rd]) | (rd_write & long_latency & pending_count == MAX_PENDING).
REQ-024 Hazard detection SHALL use only registered pending state; a same-cycle writeback does not bypass it, so the stall resolves one cycle later.
REQ-025 issue SHALL equal dec_valid & state==RUN & ~hazard & ~(dec_fence & pending_count != 0), gated to 0 during rst.
REQ-026 d_to_e_enable_ff SHALL be 1 whenever not in rst, so execute loads either the issued instruction or a NOP.
REQ-027 bubble_e SHALL equal ~issue.
REQ-028 f_to_d_enable_ff SHALL equal ~(dec_valid & ~issue) | (state == FLUSH).
REQ-029 On issue with rd_write & long_latency & rd != 0: set pending[rd] and increment pending_count.
REQ-030 On wb_enable with pending[wb_addr] = 1: clear the bit and decrement pending_count; a writeback to a non-pending register or to x0 SHALL be ignored.
REQ-031 A set and a clear in the same cycle (necessarily different registers) SHALL leave pending_count unchanged.
REQ-032 pending[0] SHALL always read 0.
REQ-033 RUN to DRAIN: dec_valid & dec_fence & pending_count != 0.
REQ-034 DRAIN to RUN: the cycle pending_count is 0; the FENCE issues from RUN on the following cycle.
REQ-035 RUN to FLUSH: issue & dec_branch_taken.
REQ-036 In FLUSH: flush_d = 1 and issue = 0 for exactly one cycle, then return to RUN.
REQ-037 dec_branch_taken on a stalled, non-issued instruction SHALL have no effect.
REQ-038 Writebacks SHALL update the pending state in every FSM state.
REQ-039 flush_d SHALL be 0 outside FLUSH.

Reset
REQ-040 While rst = 1: pending_mask = 0, pending_count = 0, state = RUN, issue = 0, f_to_d_enable_ff = 0, d_to_e_enable_ff = 0, bubble_e = 1, flush_d = 0, busy = 0.
REQ-041 rst asserted mid-DRAIN or mid-FLUSH SHALL discard all pending state, with no writeback required to recover.
REQ-042 The first cycle after reset deasserts SHALL evaluate the reset-state outputs.

Verification
REQ-043 Load-use: issue load rd=5 (long_latency); next cycle add rs1=5 -> issue=0, bubble_e=1, f_to_d_enable_ff=0 until the cycle after wb_addr=5, then issue=1.
REQ-044 Fence drain: two long-latency loads to x3 and x4 pending; FENCE arrives -> state DRAIN; after writebacks to x3 and x4, pending_count=0 -> RUN, and the FENCE issues the next cycle.
REQ-045 Branch: taken branch issues -> next cycle flush_d=1, issue=0, f_to_d_enable_ff=1; the following cycle is RUN.
REQ-046 Capacity: 8 long-latency writes to x1..x8 outstanding, ninth to x9 -> stalled; writeback to x2 -> ninth issues the cycle after, pending_count stays 8.
REQ-047 x0 and writeback corner cases: load to rd=0 -> pending_count unchanged; wb_addr=7 with nothing pending -> no change; simultaneous issue-set x10 and wb-clear x11 -> count unchanged.
REQ-048 Reset mid-drain: rst=1 while in DRAIN with count=3 -> next cycle all pending bits 0, state RUN, busy=0.
